km_modinv: RTL and testbench

- Sequential modular-inverse unit: computes inv = a^(Q-2) mod Q for prime Q (Fermat), i.e. the inverse operation of the km_rtl modular multiplier.
- Used by upstream datapaths that must divide in GF(Q): a*inv ≡ 1 (mod Q).
- Iterates left-to-right square-and-multiply over one shared combinational modular multiplier.
- Valid/ready handshakes on both sides; one operation in flight.

---
 rtl/km_pkg.sv | 11 +
 rtl/km_modinv_if.sv | 15 +
 rtl/km_modmul.sv | 18 +
 rtl/km_modinv.sv | 91 +++++++++
 tb/tb_km_modinv.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/km_pkg.sv
// Shared constants and FSM encoding for the Fermat modular-inverse unit.
package km_pkg;
    localparam int WORD_LEN = 14;
    localparam int Q        = 16381;
    localparam int LAT      = 2*WORD_LEN + 1;

    localparam logic [WORD_LEN-1:0] QW = WORD_LEN'(Q);
    localparam logic [WORD_LEN-1:0] E  = WORD_LEN'(Q - 2);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_e;
endpackage

// File: rtl/km_modinv_if.sv
// Operand/result handshake bundle; master drives operands, slave computes.
interface km_modinv_if #(parameter int W = 14);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] inv;
    logic         err;

    modport master (output in_valid, a, out_ready,
                    input  in_ready, out_valid, inv, err);
    modport slave  (input  in_valid, a, out_ready,
                    output in_ready, out_valid, inv, err);
endinterface

// File: rtl/km_modmul.sv
// Combinational modular multiplier: full-width product reduced mod MOD.
module km_modmul
    import km_pkg::*;
#(
    parameter int W   = WORD_LEN,
    parameter int MOD = Q
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] p_o
);
    localparam logic [2*W-1:0] MODW = (2*W)'(MOD);

    logic [2*W-1:0] prod;

    assign prod = x_i * y_i;
    assign p_o  = W'(prod % MODW);
endmodule

// File: rtl/km_modinv.sv
// a^(Q-2) mod Q via left-to-right square-and-multiply on one shared multiplier.
module km_modinv
    import km_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    km_modinv_if.slave  io
);
    localparam int KW = $clog2(WORD_LEN);

    state_e              state_q, state_d;
    logic [WORD_LEN-1:0] acc_q, acc_d;
    logic [WORD_LEN-1:0] a_q, a_d;
    logic [KW-1:0]       k_q, k_d;
    logic                err_q, err_d;
    logic [WORD_LEN-1:0] mm_y, mm_p;

    // Squaring and multiply-by-operand share the multiplier; only the y leg muxes.
    assign mm_y = (state_q == SQR) ? acc_q : a_q;

    km_modmul #(.W(WORD_LEN), .MOD(Q)) u_mul (
        .x_i (acc_q),
        .y_i (mm_y),
        .p_o (mm_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        k_d     = k_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d   = io.a;
                    acc_d = WORD_LEN'(1);
                    k_d   = KW'(WORD_LEN - 1);
                    if (io.a == '0 || io.a >= QW) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SQR;
                    end
                end
            end
            SQR: begin
                acc_d   = mm_p;
                state_d = MUL;
            end
            MUL: begin
                // Cycle is spent even for a zero exponent bit to keep latency fixed.
                if (E[k_q]) acc_d = mm_p;
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q - KW'(1);
                    state_d = SQR;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.inv       = (state_q == DONE && !err_q) ? acc_q : '0;
    assign io.err       = err_q;
endmodule

// File: tb/tb_km_modinv.sv
// Randomized and directed checks of km_modinv against a plain-arithmetic inverse model.
module tb_km_modinv;
    import km_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   num_correct = 0;
    int   num_wrong = 0;

    km_modinv_if #(.W(WORD_LEN)) ifc ();

    km_modinv dut (.clk(clk), .rst(rst), .io(ifc));

    logic [WORD_LEN-1:0] chk_x, chk_y, chk_p;
    km_modmul u_chk (.x_i(chk_x), .y_i(chk_y), .p_o(chk_p));

    always #5 clk = ~clk;

    // Right-to-left binary exponentiation: independent of the DUT's bit order.
    function automatic int ref_inv(input int av);
        longint r = 1;
        longint b = av;
        int     e = Q - 2;
        while (e > 0) begin
            if (e & 1) r = (r * b) % Q;
            b = (b * b) % Q;
            e = e >> 1;
        end
        return int'(r);
    endfunction

    task automatic do_op(input int av, input int hold,
                         output int r_inv, output logic r_err, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!ifc.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ifc.in_valid  = 1'b1;
        ifc.a         = WORD_LEN'(av);
        ifc.out_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
            lat++;
        end while (!ifc.out_valid && lat < 200);
        if (!ifc.out_valid) begin
            lat = -1;
            r_inv = -1;
            r_err = 1'bx;
            return;
        end
        r_inv = int'(ifc.inv);
        r_err = ifc.err;
        repeat (hold) @(negedge clk);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 ||
            ifc.inv !== '0 || ifc.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b vld=%b inv=%0d err=%b expected 1 0 0 0",
                     ifc.in_ready, ifc.out_valid, ifc.inv, ifc.err);
        end
    endtask

    task automatic test_known();
        int av[4] = '{1, 2, 3, 16380};
        int ex[4] = '{1, 8191, 10921, 16380};
        int r, lat;
        logic e;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], 0, r, e, lat);
            vectors++;
            if (r !== ex[i] || e !== 1'b0 || lat !== LAT) begin
                miscompares++;
                $display("FAIL known a=%0d: got inv=%0d err=%b lat=%0d expected %0d 0 %0d",
                         av[i], r, e, lat, ex[i], LAT);
            end
            chk_x = WORD_LEN'(av[i]);
            chk_y = WORD_LEN'(r);
            #1;
            vectors++;
            if (chk_p !== WORD_LEN'(1)) begin
                miscompares++;
                $display("FAIL modmul_check a=%0d: got %0d expected 1", av[i], chk_p);
            end
        end
    endtask

    task automatic test_illegal();
        int av[2] = '{0, 16381};
        int r, lat;
        logic e;
        for (int i = 0; i < 2; i++) begin
            do_op(av[i], 1, r, e, lat);
            vectors++;
            if (r !== 0 || e !== 1'b1 || lat !== 1) begin
                miscompares++;
                $display("FAIL illegal a=%0d: got inv=%0d err=%b lat=%0d expected 0 1 1",
                         av[i], r, e, lat);
            end
        end
        @(negedge clk);
        vectors++;
        if (ifc.err !== 1'b0 || ifc.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got err=%b vld=%b expected 0 0", ifc.err, ifc.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        int bad = 0;
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a = WORD_LEN'(3);
        @(posedge clk);
        @(negedge clk);
        ifc.a = WORD_LEN'(7);
        lat = 1;
        while (!ifc.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
        end
        for (int i = 0; i < 10; i++) begin
            if (ifc.inv !== WORD_LEN'(10921) || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        ifc.a = WORD_LEN'(2);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.out_ready = 1'b0;
        vectors++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", ifc.out_valid, ifc.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        lat = 1;
        while (!ifc.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (ifc.inv !== WORD_LEN'(8191) || lat !== LAT) begin
            miscompares++;
            $display("FAIL bp_next: got inv=%0d lat=%0d expected 8191 %0d", ifc.inv, lat, LAT);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int r, lat;
        logic e;
        int seen = 0;
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a = WORD_LEN'(5);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_reset: got vld=%b rdy=%b expected 0 1", ifc.out_valid, ifc.in_ready);
        end
        repeat (40) begin
            @(negedge clk);
            if (ifc.out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midop_stale: got %0d valid cycles expected 0", seen);
        end
        do_op(5, 0, r, e, lat);
        vectors++;
        if (r !== 13105 || e !== 1'b0 || lat !== LAT) begin
            miscompares++;
            $display("FAIL midop_rerun: got inv=%0d err=%b lat=%0d expected 13105 0 %0d", r, e, lat, LAT);
        end
    endtask

    task automatic test_random();
        int av, r, lat;
        logic e;
        longint prod;
        for (int i = 0; i < 1000; i++) begin
            av = int'($urandom_range(1, Q - 1));
            do_op(av, int'($urandom_range(0, 3)), r, e, lat);
            prod = longint'(av) * longint'(r);
            vectors++;
            if (r !== ref_inv(av) || e !== 1'b0 || lat !== LAT || (prod % Q) != 1) begin
                miscompares++;
                num_wrong++;
                $display("FAIL random a=%0d: got inv=%0d err=%b lat=%0d expected %0d 0 %0d",
                         av, r, e, lat, ref_inv(av), LAT);
            end else begin
                num_correct++;
            end
        end
        $display("random ops: %0d correct, %0d wrong", num_correct, num_wrong);
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.out_ready = 1'b0;
        chk_x = '0;
        chk_y = '0;
        test_reset();
        test_known();
        test_illegal();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
